// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// One result bit per cycle: radix-2 shift-add multiply, restoring divide.
module mul_div_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [2:0]            Op,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  Flush,
    output logic [DATA_WIDTH-1:0] Hi,
    output logic [DATA_WIDTH-1:0] Lo,
    output logic                  Busy,
    output logic                  Done,
    output logic                  DivByZero
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } op_t;

    state_t          state_q, state_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  work_q, work_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic            is_div_q, is_div_d;
    logic            neg_q, neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic            div_zero_q, div_zero_d;
    logic [W-1:0]    a_raw_q, a_raw_d;

    // Operand magnitudes for the start cycle
    logic            sgn_op;
    logic            a_neg, b_neg;
    logic [W-1:0]    mag_a, mag_b;

    always_comb begin
        sgn_op = ~Op[0];
        a_neg  = sgn_op & A[W-1];
        b_neg  = sgn_op & B[W-1];
        mag_a  = a_neg ? (~A + 1'b1) : A;
        mag_b  = b_neg ? (~B + 1'b1) : B;
    end

    // One iteration of each datapath
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next;
    logic [W:0]      rem_sh;
    logic            rem_ge;
    logic [W:0]      rem_new;
    logic [2*W-1:0]  div_next;

    always_comb begin
        mul_sum  = {1'b0, work_q[2*W-1:W]} + (work_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, work_q[W-1:1]};
        rem_sh   = {work_q[2*W-1:W], work_q[W-1]};
        rem_ge   = (rem_sh >= {1'b0, opnd_q});
        rem_new  = rem_ge ? (rem_sh - {1'b0, opnd_q}) : rem_sh;
        div_next = {rem_new[W-1:0], work_q[W-2:0], rem_ge};
    end

    // Sign-corrected results presented in FIX
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quot_fix;
    logic [W-1:0]    rem_fix;

    always_comb begin
        prod_fix = neg_q     ? (~work_q + 1'b1)          : work_q;
        quot_fix = neg_q     ? (~work_q[W-1:0] + 1'b1)   : work_q[W-1:0];
        rem_fix  = rem_neg_q ? (~work_q[2*W-1:W] + 1'b1) : work_q[2*W-1:W];
    end

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dbz_d      = 1'b0;
        cnt_d      = cnt_q;
        work_d     = work_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        a_raw_d    = a_raw_q;

        case (state_q)
            IDLE: begin
                // A flush in IDLE swallows a coincident start, including MTHI/MTLO
                if (Start && !Flush) begin
                    case (Op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            is_div_d   = Op[1];
                            neg_d      = a_neg ^ b_neg;
                            rem_neg_d  = a_neg;
                            div_zero_d = (B == '0);
                            a_raw_d    = A;
                            cnt_d      = '0;
                            if (Op[1]) begin
                                work_d = {{W{1'b0}}, mag_a};
                                opnd_d = mag_b;
                            end else begin
                                work_d = {{W{1'b0}}, mag_b};
                                opnd_d = mag_a;
                            end
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (Flush) begin
                    state_d = IDLE;
                end else begin
                    work_d = is_div_q ? div_next : mul_next;
                    if (cnt_q == CW'(W - 1)) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!Flush) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (div_zero_q) begin
                        lo_d  = '1;
                        hi_d  = a_raw_q;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d = quot_fix;
                        hi_d = rem_fix;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            cnt_q      <= '0;
            work_q     <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            a_raw_q    <= '0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            a_raw_q    <= a_raw_d;
        end
    end

    assign Hi        = hi_q;
    assign Lo        = lo_q;
    assign Busy      = (state_q != IDLE);
    assign Done      = done_q;
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: expected HI/LO queued at start,
// popped and compared when Done pulses.
module tb_mul_div_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A, B;
    logic        Flush;
    logic [31:0] Hi, Lo;
    logic        Busy, Done, DivByZero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb_q[$];

    mul_div_unit #(.DATA_WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .Flush(Flush), .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done),
        .DivByZero(DivByZero)
    );

    always #5 Clk = ~Clk;

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        m;
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        m.dbz = 1'b0;
        m.hi  = '0;
        m.lo  = '0;
        case (op)
            3'd0: begin p = sa * sb; m.hi = p[63:32]; m.lo = p[31:0]; end
            3'd1: begin p = {32'b0, a} * {32'b0, b}; m.hi = p[63:32]; m.lo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    m.lo = 32'hFFFF_FFFF; m.hi = a; m.dbz = 1'b1;
                end else if (op == 3'd2) begin
                    q = sa / sb; r = sa % sb;
                    m.lo = q[31:0]; m.hi = r[31:0];
                end else begin
                    m.lo = a / b; m.hi = a % b;
                end
            end
        endcase
        return m;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1; Op = op; A = a; B = b;
        tick();
        Start = 1'b0;
    endtask

    // Advances until Done is seen or the budget expires; returns cycles waited
    task automatic run_to_done(output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = 0;
        while (Done !== 1'b1 && lat < 100) begin
            if (Busy === 1'b1) busy_cycles++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0; Flush = 1'b0;
        tick(); tick();
        checks++; if (Hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want %h", Hi, 32'h0); end
        checks++; if (Lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want %h", Lo, 32'h0); end
        checks++; if ({Busy, Done, DivByZero} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {Busy, Done, DivByZero}); end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_multu();
        int lat, bc;
        exp_t e;
        sb_q.push_back(model(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
        start_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_to_done(lat, bc);
        e = sb_q.pop_front();
        checks++; if (lat !== 33) begin errors++; $display("FAIL multu_latency got %0d want 33", lat); end
        checks++; if (bc !== 33) begin errors++; $display("FAIL multu_busy_cycles got %0d want 33", bc); end
        checks++; if (Hi !== 32'hFFFF_FFFE || Hi !== e.hi) begin errors++; $display("FAIL multu_hi got %h want %h", Hi, e.hi); end
        checks++; if (Lo !== 32'h0000_0001 || Lo !== e.lo) begin errors++; $display("FAIL multu_lo got %h want %h", Lo, e.lo); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done got %b want 0", Busy); end
        tick();
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse got %b want 0", Done); end
    endtask

    task automatic test_signed();
        int lat, bc;
        exp_t e;
        sb_q.push_back(model(3'd0, 32'hFFFF_FFFD, 32'd7));
        start_op(3'd0, 32'hFFFF_FFFD, 32'd7);
        run_to_done(lat, bc);
        e = sb_q.pop_front();
        checks++; if ({Hi, Lo} !== {e.hi, e.lo} || Lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_neg got %h_%h want %h_%h", Hi, Lo, e.hi, e.lo); end
        tick();
        sb_q.push_back(model(3'd2, 32'hFFFF_FFF9, 32'd2));
        start_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        run_to_done(lat, bc);
        e = sb_q.pop_front();
        checks++; if (Lo !== e.lo || Lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_quot got %h want %h", Lo, e.lo); end
        checks++; if (Hi !== e.hi || Hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_rem got %h want %h", Hi, e.hi); end
        checks++; if (DivByZero !== 1'b0) begin errors++; $display("FAIL div_neg_dbz got %b want 0", DivByZero); end
        tick();
    endtask

    task automatic test_div_by_zero();
        int lat, bc;
        exp_t e;
        sb_q.push_back(model(3'd3, 32'd100, 32'd0));
        start_op(3'd3, 32'd100, 32'd0);
        run_to_done(lat, bc);
        e = sb_q.pop_front();
        checks++; if (lat !== 33) begin errors++; $display("FAIL dbz_latency got %0d want 33", lat); end
        checks++; if (Lo !== e.lo || Hi !== e.hi) begin errors++; $display("FAIL dbz_result got %h_%h want %h_%h", Hi, Lo, e.hi, e.lo); end
        checks++; if (DivByZero !== e.dbz) begin errors++; $display("FAIL dbz_flag got %b want %b", DivByZero, e.dbz); end
        tick();
        checks++; if ({Done, DivByZero} !== 2'b00) begin errors++; $display("FAIL dbz_pulse got %b want 00", {Done, DivByZero}); end
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] lo_before;
        lo_before = Lo;
        Start = 1'b1; Op = 3'd4; A = 32'h1234_5678;
        tick();
        checks++; if (Hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi got %h want %h", Hi, 32'h1234_5678); end
        checks++; if (Lo !== lo_before) begin errors++; $display("FAIL mthi_lo_kept got %h want %h", Lo, lo_before); end
        checks++; if ({Busy, Done} !== 2'b00) begin errors++; $display("FAIL mthi_flags got %b want 00", {Busy, Done}); end
        Op = 3'd5; A = 32'h9ABC_DEF0;
        tick();
        Start = 1'b0;
        checks++; if (Lo !== 32'h9ABC_DEF0) begin errors++; $display("FAIL mtlo got %h want %h", Lo, 32'h9ABC_DEF0); end
        checks++; if (Hi !== 32'h1234_5678) begin errors++; $display("FAIL mtlo_hi_kept got %h want %h", Hi, 32'h1234_5678); end
        tick();
        checks++; if ({Busy, Done} !== 2'b00) begin errors++; $display("FAIL mtlo_flags got %b want 00", {Busy, Done}); end
    endtask

    task automatic test_flush_idle();
        Flush = 1'b1; Start = 1'b1; Op = 3'd4; A = 32'hDEAD_BEEF;
        tick();
        Flush = 1'b0; Start = 1'b0;
        checks++; if (Hi !== 32'h1234_5678) begin errors++; $display("FAIL flush_idle_hi got %h want %h", Hi, 32'h1234_5678); end
        Flush = 1'b1; Start = 1'b1; Op = 3'd1; A = 32'd3; B = 32'd4;
        tick();
        Flush = 1'b0; Start = 1'b0;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy got %b want 0", Busy); end
    endtask

    task automatic test_flush_run();
        int dones;
        start_op(3'd3, 32'd1000, 32'd7);
        repeat (9) tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", Busy); end
        checks++; if ({Hi, Lo} !== {32'h1234_5678, 32'h9ABC_DEF0}) begin errors++; $display("FAIL flush_hilo got %h_%h want 12345678_9abcdef0", Hi, Lo); end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done === 1'b1) dones++;
            tick();
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL flush_no_done got %0d want 0", dones); end
        start_op(3'd3, 32'd1000, 32'd7);
        repeat (19) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++; if ({Hi, Lo} !== 64'h0) begin errors++; $display("FAIL midreset_hilo got %h_%h want 0_0", Hi, Lo); end
        checks++; if ({Busy, Done, DivByZero} !== 3'b000) begin errors++; $display("FAIL midreset_flags got %b want 000", {Busy, Done, DivByZero}); end
        repeat (40) tick();
        checks++; if ({Hi, Lo, Done} !== 65'h0) begin errors++; $display("FAIL midreset_discard got %h_%h done %b want 0", Hi, Lo, Done); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        exp_t e;
        sb_q.push_back(model(3'd2, 32'h8000_0000, 32'hFFFF_FFFF));
        start_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (4) tick();
        start_op(3'd1, 32'd5, 32'd6);
        run_to_done(lat, bc);
        e = sb_q.pop_front();
        checks++; if (Lo !== e.lo || Lo !== 32'h8000_0000) begin errors++; $display("FAIL ovf_quot got %h want %h", Lo, e.lo); end
        checks++; if (Hi !== e.hi || Hi !== 32'h0) begin errors++; $display("FAIL ovf_rem got %h want %h", Hi, e.hi); end
        checks++; if (DivByZero !== 1'b0) begin errors++; $display("FAIL ovf_dbz got %b want 0", DivByZero); end
        sb_q.push_back(model(3'd3, 32'd1000, 32'd7));
        start_op(3'd3, 32'd1000, 32'd7);
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b want 1", Busy); end
        run_to_done(lat, bc);
        e = sb_q.pop_front();
        checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", lat); end
        checks++; if ({Hi, Lo} !== {e.hi, e.lo} || Lo !== 32'd142) begin errors++; $display("FAIL b2b_result got %h_%h want %h_%h", Hi, Lo, e.hi, e.lo); end
        tick();
    endtask

    task automatic test_random();
        int lat, bc;
        exp_t e;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom();
            b  = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom() : 32'($urandom_range(1, 300)));
            if (i == 5) b = 32'hFFFF_FFF0;
            sb_q.push_back(model(op, a, b));
            start_op(op, a, b);
            run_to_done(lat, bc);
            e = sb_q.pop_front();
            checks++;
            if ({Hi, Lo, DivByZero} !== {e.hi, e.lo, e.dbz} || lat !== 33) begin
                errors++;
                $display("FAIL rand_%0d op %0d a %h b %h got %h_%h dbz %b lat %0d want %h_%h dbz %b lat 33",
                         i, op, a, b, Hi, Lo, DivByZero, lat, e.hi, e.lo, e.dbz);
            end
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_signed();
        test_div_by_zero();
        test_mthi_mtlo();
        test_flush_idle();
        test_flush_run();
        test_back_to_back();
        test_random();
        checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain got %0d want 0", sb_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
